// File: rtl/alu_cmd_seq_if.sv
// Handshake and ALU bus for alu_cmd_seq: command input, ALU drive/return,
// response output and status. The slave modport is the sequencer side.
interface alu_cmd_seq_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_a;
   logic [3:0] cmd_b;
   logic [1:0] cmd_op;
   logic       alu_en;
   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic [1:0] alu_op;
   logic [4:0] alu_c;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [4:0] rsp_c;
   logic [1:0] rsp_op;
   logic       rsp_zero;
   logic       rsp_neg;
   logic       busy;
   logic [7:0] ops_done;

   modport slave (
      input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_c, rsp_ready,
      output cmd_ready, alu_en, alu_a, alu_b, alu_op,
             rsp_valid, rsp_c, rsp_op, rsp_zero, rsp_neg, busy, ops_done
   );

   modport master (
      output cmd_valid, cmd_a, cmd_b, cmd_op, alu_c, rsp_ready,
      input  cmd_ready, alu_en, alu_a, alu_b, alu_op,
             rsp_valid, rsp_c, rsp_op, rsp_zero, rsp_neg, busy, ops_done
   );
endinterface

// File: rtl/alu_cmd_seq.sv
// Command sequencer: queues ALU commands in a FIFO, issues one at a time to an
// external registered ALU and holds each result until the consumer takes it.
module alu_cmd_seq #(
   parameter int unsigned DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   alu_cmd_seq_if.slave bus
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned EW = 10;

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, HOLD} state_t;

   state_t        state_q, state_d;

   logic [EW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;

   logic          alu_en_q, alu_en_d;
   logic [3:0]    alu_a_q, alu_a_d;
   logic [3:0]    alu_b_q, alu_b_d;
   logic [1:0]    alu_op_q, alu_op_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [4:0]    rsp_c_q, rsp_c_d;
   logic [1:0]    rsp_op_q, rsp_op_d;
   logic [7:0]    ops_done_q, ops_done_d;

   logic          full, empty, push, pop, rsp_hs;
   logic [EW-1:0] head;

   assign full   = (cnt_q == (AW+1)'(DEPTH));
   assign empty  = (cnt_q == '0);
   // Full blocks the push even when IDLE pops in the same cycle.
   assign push   = bus.cmd_valid && !full;
   assign pop    = (state_q == IDLE) && !empty;
   assign rsp_hs = rsp_valid_q && bus.rsp_ready;
   assign head   = mem_q[rd_ptr_q];

   // FIFO storage carries no reset; occupancy is governed by cnt_q alone.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {bus.cmd_a, bus.cmd_b, bus.cmd_op};
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + (AW+1)'(1);
         2'b01:   cnt_d = cnt_q - (AW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!empty) state_d = ISSUE;
         ISSUE:   state_d = CAPTURE;
         CAPTURE: state_d = HOLD;
         HOLD:    if (rsp_hs) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      alu_en_d    = 1'b0;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_op_d    = alu_op_q;
      rsp_valid_d = rsp_valid_q;
      rsp_c_d     = rsp_c_q;
      rsp_op_d    = rsp_op_q;
      ops_done_d  = ops_done_q;
      case (state_q)
         IDLE: begin
            if (!empty) begin
               alu_en_d = 1'b1;
               {alu_a_d, alu_b_d, alu_op_d} = head;
            end
         end
         CAPTURE: begin
            rsp_valid_d = 1'b1;
            rsp_c_d     = bus.alu_c;
            rsp_op_d    = alu_op_q;
         end
         HOLD: begin
            if (rsp_hs) begin
               rsp_valid_d = 1'b0;
               ops_done_d  = ops_done_q + 8'd1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         alu_en_q    <= 1'b0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_op_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_c_q     <= '0;
         rsp_op_q    <= '0;
         ops_done_q  <= '0;
      end else begin
         alu_en_q    <= alu_en_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_op_q    <= alu_op_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_c_q     <= rsp_c_d;
         rsp_op_q    <= rsp_op_d;
         ops_done_q  <= ops_done_d;
      end
   end

   assign bus.cmd_ready = !full;
   assign bus.alu_en    = alu_en_q;
   assign bus.alu_a     = alu_a_q;
   assign bus.alu_b     = alu_b_q;
   assign bus.alu_op    = alu_op_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_c     = rsp_c_q;
   assign bus.rsp_op    = rsp_op_q;
   assign bus.rsp_zero  = (rsp_c_q == '0);
   assign bus.rsp_neg   = rsp_c_q[4];
   assign bus.busy      = (state_q != IDLE) || !empty;
   assign bus.ops_done  = ops_done_q;

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Bench for alu_cmd_seq: registered ALU model, command driver queue and a
// response scoreboard, plus directed latency, backpressure, reset and wrap runs.
module tb_alu_cmd_seq;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [1:0] op;
      logic [4:0] c;
   } cmd_t;

   logic clk;
   logic rst;
   alu_cmd_seq_if bus();

   alu_cmd_seq #(.DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int unsigned checks   = 0;
   int unsigned failures = 0;
   cmd_t        cmd_q[$];
   cmd_t        sb[$];
   logic [7:0]  exp_ops  = 8'd0;
   cmd_t        vec [10];

   always #5 clk = ~clk;

   function automatic logic [4:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                            input logic [1:0] op);
      logic [4:0] sa, sbv;
      sa  = {a[3], a};
      sbv = {b[3], b};
      case (op)
         2'd0:    return sa + sbv;
         2'd1:    return sa - sbv;
         2'd2:    return sa & sbv;
         default: return sa | sbv;
      endcase
   endfunction

   // External ALU: result registered on the edge that ends the alu_en cycle.
   always @(posedge clk or negedge rst) begin
      if (!rst) bus.alu_c <= 5'd0;
      else if (bus.alu_en) bus.alu_c <= alu_model(bus.alu_a, bus.alu_b, bus.alu_op);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic drive_cmd();
      if (cmd_q.size() != 0) begin
         bus.cmd_valid = 1'b1;
         bus.cmd_a     = cmd_q[0].a;
         bus.cmd_b     = cmd_q[0].b;
         bus.cmd_op    = cmd_q[0].op;
      end else begin
         bus.cmd_valid = 1'b0;
      end
   endtask

   task automatic step();
      logic acc, hs;
      cmd_t e;
      @(negedge clk);
      acc = bus.cmd_valid && bus.cmd_ready;
      hs  = bus.rsp_valid && bus.rsp_ready;
      if (acc) sb.push_back(cmd_q[0]);
      if (hs) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rsp_unexpected actual=%0h required=none", bus.rsp_c);
         end else begin
            e = sb.pop_front();
            check("rsp_c", 32'(bus.rsp_c), 32'(e.c));
            check("rsp_op", 32'(bus.rsp_op), 32'(e.op));
            check("rsp_zero", 32'(bus.rsp_zero), 32'(e.c == 5'd0));
            check("rsp_neg", 32'(bus.rsp_neg), 32'(e.c[4]));
         end
         exp_ops = exp_ops + 8'd1;
      end
      @(posedge clk);
      #1;
      if (acc) void'(cmd_q.pop_front());
      if (hs) check("ops_done", 32'(bus.ops_done), 32'(exp_ops));
      drive_cmd();
   endtask

   task automatic push_cmd(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                           input logic [4:0] c);
      cmd_t t;
      t.a = a; t.b = b; t.op = op; t.c = c;
      cmd_q.push_back(t);
      drive_cmd();
   endtask

   task automatic push_rand();
      logic [3:0] a, b;
      logic [1:0] op;
      a  = 4'($urandom_range(15, 0));
      b  = 4'($urandom_range(15, 0));
      op = 2'($urandom_range(3, 0));
      push_cmd(a, b, op, alu_model(a, b, op));
   endtask

   task automatic drain();
      int unsigned n = 0;
      while ((cmd_q.size() != 0 || sb.size() != 0 || bus.busy || bus.rsp_valid) && n < 6000) begin
         step();
         n++;
      end
      check("drain_done", 32'(n < 6000), 32'd1);
   endtask

   task automatic latency_seq();
      push_cmd(4'd7, 4'd7, 2'd0, 5'd14);
      step();
      check("lat_t0_alu_en", 32'(bus.alu_en), 32'd0);
      check("lat_t0_busy", 32'(bus.busy), 32'd1);
      step();
      check("lat_t1_alu_en", 32'(bus.alu_en), 32'd1);
      check("lat_t1_alu_a", 32'(bus.alu_a), 32'd7);
      check("lat_t1_alu_b", 32'(bus.alu_b), 32'd7);
      check("lat_t1_alu_op", 32'(bus.alu_op), 32'd0);
      step();
      check("lat_t2_alu_en", 32'(bus.alu_en), 32'd0);
      check("lat_t2_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("lat_t2_alu_a_held", 32'(bus.alu_a), 32'd7);
      step();
      check("lat_t3_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("lat_t3_rsp_c", 32'(bus.rsp_c), 32'h0E);
      drain();
   endtask

   initial begin
      int unsigned issues;
      int unsigned seen;
      clk           = 1'b0;
      rst           = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_a     = 4'd0;
      bus.cmd_b     = 4'd0;
      bus.cmd_op    = 2'd0;
      bus.rsp_ready = 1'b1;

      vec[0] = '{4'd7,     4'd7,     2'd0, 5'h0E};
      vec[1] = '{4'b1000,  4'd7,     2'd1, 5'h11};
      vec[2] = '{4'd3,     4'd3,     2'd1, 5'h00};
      vec[3] = '{4'b1000,  4'b1000,  2'd0, 5'h10};
      vec[4] = '{4'd7,     4'b1000,  2'd1, 5'h0F};
      vec[5] = '{4'b0110,  4'b1100,  2'd2, 5'h04};
      vec[6] = '{4'b1001,  4'b0010,  2'd3, 5'h1B};
      vec[7] = '{4'b1111,  4'b1000,  2'd2, 5'h18};
      vec[8] = '{4'd0,     4'd0,     2'd3, 5'h00};
      vec[9] = '{4'b1111,  4'd1,     2'd0, 5'h00};

      #1 rst = 1'b0;
      #1;
      check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      check("rst_alu_en", 32'(bus.alu_en), 32'd0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_rsp_c", 32'(bus.rsp_c), 32'd0);
      check("rst_ops_done", 32'(bus.ops_done), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      step();
      step();
      rst = 1'b1;

      latency_seq();

      for (int unsigned i = 0; i < 10; i++) begin
         push_cmd(vec[i].a, vec[i].b, vec[i].op, vec[i].c);
         drain();
      end

      // Backpressure: one result held, DEPTH commands queued, sixth refused.
      bus.rsp_ready = 1'b0;
      for (int unsigned i = 0; i < 6; i++) push_rand();
      for (int unsigned i = 0; i < 12; i++) step();
      check("bp_pending", 32'(cmd_q.size()), 32'd1);
      check("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_rsp_c_a", 32'(bus.rsp_c), 32'(sb[0].c));
      step();
      step();
      check("bp_rsp_c_b", 32'(bus.rsp_c), 32'(sb[0].c));
      bus.rsp_ready = 1'b1;
      step();
      check("full_pop_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      check("full_pop_busy", 32'(bus.busy), 32'd1);
      step();
      check("full_pop_alu_en", 32'(bus.alu_en), 32'd1);
      check("full_pop_cmd_ready_after", 32'(bus.cmd_ready), 32'd1);
      drain();

      // Reset during the second ISSUE with further commands queued.
      for (int unsigned i = 0; i < 5; i++) push_rand();
      issues = 0;
      for (int unsigned i = 0; i < 60 && issues < 2; i++) begin
         step();
         if (bus.alu_en) issues++;
      end
      check("rstmid_reached_issue", 32'(issues), 32'd2);
      #2 rst = 1'b0;
      #1;
      check("rstmid_alu_en", 32'(bus.alu_en), 32'd0);
      check("rstmid_alu_a", 32'(bus.alu_a), 32'd0);
      check("rstmid_alu_b", 32'(bus.alu_b), 32'd0);
      check("rstmid_alu_op", 32'(bus.alu_op), 32'd0);
      check("rstmid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rstmid_rsp_c", 32'(bus.rsp_c), 32'd0);
      check("rstmid_rsp_op", 32'(bus.rsp_op), 32'd0);
      check("rstmid_ops_done", 32'(bus.ops_done), 32'd0);
      check("rstmid_busy", 32'(bus.busy), 32'd0);
      check("rstmid_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      cmd_q.delete();
      sb.delete();
      exp_ops = 8'd0;
      drive_cmd();
      step();
      step();
      rst = 1'b1;
      seen = 0;
      for (int unsigned i = 0; i < 20; i++) begin
         step();
         if (bus.rsp_valid) seen++;
      end
      check("rstmid_no_rsp", 32'(seen), 32'd0);
      check("rstmid_idle_busy", 32'(bus.busy), 32'd0);

      latency_seq();

      // ops_done wrap: one handshake since reset so far.
      for (int unsigned i = 0; i < 255; i++) push_rand();
      drain();
      check("wrap_256", 32'(bus.ops_done), 32'd0);
      push_rand();
      drain();
      check("wrap_257", 32'(bus.ops_done), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_cmd_seq.md
ALU_CMD_SEQ -- requirements
Module: alu_cmd_seq

Interface
REQ-001 Parameter: DEPTH, 4, command FIFO depth in entries; power of two, at least 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  command FIFO can accept.
REQ-006 cmd_a, cmd_b  input  4 each  signed operands.
REQ-007 cmd_op  input  2  opcode: 00 add, 01 sub, 10 and, 11 or.
REQ-008 alu_en  output  1  enable to the sequential ALU.
REQ-009 alu_a, alu_b  output  4 each  signed operands to the ALU.
REQ-010 alu_op  output  2  opcode to the ALU.
REQ-011 alu_c  input  5  signed registered ALU result, valid one cycle after an alu_en cycle.
REQ-012 rsp_valid  output  1  result available.
REQ-013 rsp_ready  input  1  consumer accepts result.
REQ-014 rsp_c  output  5  signed result; rsp_op  output  2  opcode of that result.
REQ-015 rsp_zero, rsp_neg  output  1 each  flags of rsp_c.
REQ-016 busy  output  1  high whenever state is not IDLE or FIFO is non-empty.
REQ-017 ops_done  output  8  count of completed response handshakes.

Function
REQ-018 Command FIFO SHALL push {cmd_a,cmd_b,cmd_op} on cmd_valid && cmd_ready; cmd_ready = !full; no bypass to ALU; pointers wrap modulo DEPTH.
REQ-019 Push and pop in the same cycle SHALL both occur; count unchanged; when full, cmd_ready stays 0 that cycle regardless of a simultaneous pop.
REQ-020 FSM states SHALL be IDLE, ISSUE, CAPTURE, HOLD.
REQ-021 IDLE: if FIFO non-empty, pop head, register it onto alu_a/alu_b/alu_op, alu_en<=1, go ISSUE; else stay, alu_en=0.
REQ-022 ISSUE: alu_en SHALL be high for exactly this one cycle; alu_en<=0, go CAPTURE.
REQ-023 CAPTURE: rsp_c<=alu_c, rsp_op<=alu_op, rsp_valid<=1, go HOLD.
REQ-024 HOLD: rsp_valid, rsp_c, rsp_op, flags SHALL hold stable until rsp_valid && rsp_ready; on handshake rsp_valid<=0, ops_done<=ops_done+1, go IDLE.
REQ-025 Latency: command accepted into an empty FIFO at edge T while IDLE SHALL yield alu_en at T+1 and rsp_valid at T+3; minimum 4 cycles per operation.
REQ-026 alu_a/alu_b/alu_op SHALL hold their last issued values outside ISSUE.
REQ-027 rsp_zero = (rsp_c == 0); rsp_neg = rsp_c[4]; both derived from the registered rsp_c.
REQ-028 Responses SHALL return in command order; no command dropped or duplicated.
REQ-029 ops_done SHALL wrap 255 -> 0 without flag.

Reset
REQ-030 rst low SHALL immediately force: state IDLE, FIFO empty, cmd_ready 1 (after flops clear), alu_en 0, alu_a/alu_b/alu_op 0, rsp_valid 0, rsp_c 0, rsp_op 0, ops_done 0, busy 0.
REQ-031 Reset asserted mid-operation (any state) SHALL discard the in-flight command and all queued commands; no response is produced for them.
REQ-032 First command after reset release SHALL follow REQ-025 timing exactly.

Verification
REQ-033 Add: push A=7,B=7,op=00 -> alu_en one-cycle pulse with alu_a=7,alu_b=7; rsp_c=14 (01110) at acceptance+3, rsp_zero=0, rsp_neg=0.
REQ-034 Sub: push A=-8,B=7,op=01 -> rsp_c=-15 (10001), rsp_neg=1; then A=3,B=3,op=01 -> rsp_c=0, rsp_zero=1.
REQ-035 Backpressure: rsp_ready=0, push 6 commands back-to-back -> 5 accepted (1 in HOLD + DEPTH=4 queued), cmd_ready=0, rsp_c stable; release rsp_ready -> 5 results in push order.
REQ-036 Reset mid-op: assert rst during ISSUE with 3 queued -> all outputs 0 immediately; after release no rsp_valid appears without a new push.
REQ-037 Counter wrap: 256 completed handshakes -> ops_done reads 0; 257th -> 1.
REQ-038 Simultaneous push/pop on full FIFO -> cmd_ready 0 that cycle, no entry lost, order preserved.
